timer_param_ctrl: RTL
=====================

Name: timer_param_ctrl

Overview:
- Configuration controller for the alarm's single shared countdown timer.
- Holds the four programmable delay values (arm, driver door, passenger door, alarm-on).
- Runs the user reprogram handshake: latch selector and value on a button press, validate, write, acknowledge.
- Drives the selected delay onto the timer's load value. Sits between the debounced user inputs and the alarm FSM/timer.

Parameters:
- WIDTH, 4, width of each delay value and of t_value.
- DEF_ARM, 6, reset value of the arm delay.
- DEF_DRIVER, 8, reset value of the driver-door delay.
- DEF_PASSENGER, 14, reset value of the passenger-door delay.
- DEF_ALARM, 10, reset value of the alarm-on delay.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- sel  in  2  parameter to reprogram: 00 arm, 01 driver, 10 passenger, 11 alarm.
- value  in  WIDTH  new delay value; 0 is illegal.
- reprogram  in  1  debounced reprogram button, level.
- lock  in  1  high while the alarm is armed or triggered; used only with PARAM_LOCK_EN.
- interval  in  2  delay requested by the alarm FSM; same encoding as sel.
- t_value  out  WIDTH  delay selected by interval; the timer's load value.
- reprog_pulse  out  1  one-cycle pulse after a successful write; the alarm FSM returns to its SET state on it.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0):
  - Delay registers load DEF_ARM, DEF_DRIVER, DEF_PASSENGER, DEF_ALARM.
  - FSM goes to IDLE; reprog_pulse=0, cfg_err=0, busy=0.
  - Edge register reprogram_d resets to 1, so a button held through reset release causes no write; it must be released and pressed again.
- Edge detect:
  - reprogram_d is registered every cycle.
  - A press is reprogram=1 while reprogram_d=0, sampled only in IDLE. Presses in any other state are ignored.
- FSM states:
  - IDLE: on a press, latch sel_q<=sel and value_q<=value, go to CHECK.
  - CHECK: if value_q==0, go to ERROR; otherwise go to WRITE.
  - WRITE: the register selected by sel_q takes value_q on the clock edge leaving WRITE; next state DONE.
  - DONE: reprog_pulse=1 for exactly this cycle; next state WAIT_REL.
  - ERROR: cfg_err=1 for exactly this cycle; no register changes; next state WAIT_REL.
  - WAIT_REL: stay until reprogram=0, then go to IDLE. A long hold therefore writes once only.
- Timing:
  - Press sampled at edge N: CHECK in cycle N+1, WRITE in N+2, DONE in N+3.
  - Press to reprog_pulse latency is 3 cycles.
  - The new value is visible on t_value from the DONE cycle onward.
- t_value:
  - Combinational mux of the four registers by interval.
  - Shows the old value through the WRITE cycle, including when interval equals the parameter being written.
- sel/value changes after the latch have no effect on the write in progress.
- Reset mid-operation: defaults are restored immediately, the FSM goes to IDLE, and any in-flight write is discarded.
- Unsigned values. Full range 1..2^WIDTH-1 is accepted; there is no clamping and no wrap.

Optional Feature:
- PARAM_LOCK_EN defined:
  - In CHECK, lock=1 routes to ERROR (cfg_err pulse, no write), ahead of the zero check.
  - lock is sampled in CHECK only.
- PARAM_LOCK_EN undefined: lock is ignored; no other behaviour changes.

Test Plan:
- Reset release, interval swept 00..11 -> t_value 6, 8, 14, 10; all pulses 0; busy 0.
- sel=10, value=5, press -> reprog_pulse exactly 3 cycles after the press edge; interval=10 then gives 5; other registers unchanged.
- value=0, press -> cfg_err one cycle 2 cycles after the press edge; no reprog_pulse; all values unchanged.
- Press held 50 cycles with value changing while held -> exactly one write (the value at the press); the next press is accepted only after release.
- reset=0 asserted during WRITE after a sel=00, value=3 press -> arm delay reads 6; busy 0 immediately; no pulse.
- PARAM_LOCK_EN defined, lock=1, sel=01, value=9, press -> cfg_err pulse, driver delay stays 8; lock=0, repeat -> driver delay becomes 9.

Source files
------------

// File: rtl/timer_param_ctrl.sv
// rtl/timer_param_ctrl.sv - delay register bank and reprogram handshake for the alarm countdown timer
// Optional feature macro: PARAM_LOCK_EN (reject writes while the alarm is armed or triggered).
module timer_param_ctrl #(
    parameter int WIDTH         = 4,
    parameter int DEF_ARM       = 6,
    parameter int DEF_DRIVER    = 8,
    parameter int DEF_PASSENGER = 14,
    parameter int DEF_ALARM     = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] value,
    input  logic             reprogram,
    input  logic             lock,
    input  logic [1:0]       interval,
    output logic [WIDTH-1:0] t_value,
    output logic             reprog_pulse,
    output logic             cfg_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERROR    = 3'd4,
        ST_WAIT_REL = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] delay_q [4];
    logic [WIDTH-1:0] delay_d [4];
    logic             reprogram_dly_q, reprogram_dly_d;
    logic             press;

    // Edge register starts high so a button held through reset release is not a press.
    assign press = reprogram & ~reprogram_dly_q;

`ifndef PARAM_LOCK_EN
    logic unused_lock;
    assign unused_lock = lock;
`endif

    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        value_d         = value_q;
        delay_d         = delay_q;
        reprogram_dly_d = reprogram;

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    sel_d   = sel;
                    value_d = value;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
`ifdef PARAM_LOCK_EN
                if (lock || (value_q == '0)) state_d = ST_ERROR;
`else
                if (value_q == '0) state_d = ST_ERROR;
`endif
                else state_d = ST_WRITE;
            end
            ST_WRITE: begin
                delay_d[sel_q] = value_q;
                state_d        = ST_DONE;
            end
            ST_DONE:  state_d = ST_WAIT_REL;
            ST_ERROR: state_d = ST_WAIT_REL;
            ST_WAIT_REL: begin
                if (!reprogram) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            sel_q           <= '0;
            value_q         <= '0;
            reprogram_dly_q <= 1'b1;
            delay_q[0]      <= WIDTH'(DEF_ARM);
            delay_q[1]      <= WIDTH'(DEF_DRIVER);
            delay_q[2]      <= WIDTH'(DEF_PASSENGER);
            delay_q[3]      <= WIDTH'(DEF_ALARM);
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            value_q         <= value_d;
            reprogram_dly_q <= reprogram_dly_d;
            delay_q         <= delay_d;
        end
    end

    assign t_value      = delay_q[interval];
    assign reprog_pulse = (state_q == ST_DONE);
    assign cfg_err      = (state_q == ST_ERROR);
    assign busy         = (state_q != ST_IDLE);

endmodule
